// File: rtl/rw_stage_pipelined.sv
// Register-writeback stage: picks ALU/load/link data and drives the RF write port one cycle after accept.
// Latency 1 cycle; in_ready depends only on state, and the stage refuses input forever once a halt retires.
module rw_stage_pipelined #(
    parameter int          DATA_W   = 32,
    parameter int          RADDR_W  = 4,
    parameter int          RA_IDX   = 15,
    parameter int          PC_INC   = 4,
    parameter int          CTRL_W   = 22,
    parameter int          LD_BIT   = 1,
    parameter int          WB_BIT   = 6,
    parameter int          CALL_BIT = 8,
    parameter int          RD_LSB   = 22,
    parameter logic [4:0]  HALT_OPC = 5'b11111,
    parameter int          CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [DATA_W-1:0]   in_ld_result,
    input  logic [DATA_W-1:0]   in_alu_result,
    input  logic [31:0]         in_ir,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic                wb_en,
    output logic [RADDR_W-1:0]  wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                halted,
    output logic [CNT_W-1:0]    retired_cnt
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 wb_en_q, wb_en_d;
    logic [RADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic accept, is_halt, is_call, is_ld, is_wb;

    // Only a few control and IR bits matter here; the rest pass through other stages.
    logic unused_bits;
    assign unused_bits = ^{in_ctrl, in_ir};

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid & in_ready;
    assign is_halt  = (in_ir[31:27] == HALT_OPC);
    assign is_call  = in_ctrl[CALL_BIT];
    assign is_ld    = in_ctrl[LD_BIT];
    assign is_wb    = in_ctrl[WB_BIT];

    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            // Call takes priority over load when both flags are set.
            if (is_call) begin
                wb_data_d = in_pc + DATA_W'(PC_INC);
                wb_rd_d   = RADDR_W'(RA_IDX);
            end else if (is_ld) begin
                wb_data_d = in_ld_result;
                wb_rd_d   = in_ir[RD_LSB +: RADDR_W];
            end else begin
                wb_data_d = in_alu_result;
                wb_rd_d   = in_ir[RD_LSB +: RADDR_W];
            end
            if (is_halt) begin
                state_d = HALTED;
            end else begin
                wb_en_d = is_wb;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign halted      = (state_q == HALTED);
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_rw_stage_pipelined.sv
// Bench for rw_stage_pipelined: write-port scoreboard plus per-scenario direct checks.
module tb_rw_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready3;
    logic [31:0] in_pc = '0, in_ld_result = '0, in_alu_result = '0, in_ir = '0;
    logic [21:0] in_ctrl = '0;
    logic        wb_en, wb_en3, halted, halted3;
    logic [3:0]  wb_rd, wb_rd3;
    logic [31:0] wb_data, wb_data3, retired_cnt;
    logic [2:0]  retired_cnt3;

    int total = 0;
    int bad = 0;
    int wb_seen = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    bit          m_halted = 0;
    int unsigned m_cnt = 0;
    int unsigned m_cnt3 = 0;

    always #5 clk = ~clk;

    rw_stage_pipelined dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ld_result(in_ld_result), .in_alu_result(in_alu_result),
        .in_ir(in_ir), .in_ctrl(in_ctrl), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .halted(halted), .retired_cnt(retired_cnt)
    );

    rw_stage_pipelined #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_pc(in_pc), .in_ld_result(in_ld_result), .in_alu_result(in_alu_result),
        .in_ir(in_ir), .in_ctrl(in_ctrl), .wb_en(wb_en3), .wb_rd(wb_rd3),
        .wb_data(wb_data3), .halted(halted3), .retired_cnt(retired_cnt3)
    );

    function automatic logic [21:0] mkctrl(bit ld, bit wb, bit call);
        logic [21:0] c;
        c = '0;
        c[1] = ld;
        c[6] = wb;
        c[8] = call;
        return c;
    endfunction

    function automatic logic [31:0] mkir(logic [4:0] opc, logic [3:0] rd);
        logic [31:0] ir;
        ir = '0;
        ir[31:27] = opc;
        ir[25:22] = rd;
        return ir;
    endfunction

    // Write-port monitor: every wb_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wb_en) begin
            exp_t e;
            wb_seen++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_write: got rd=%0d data=%h, expected no write", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic send(logic [31:0] pc, logic [31:0] ld, logic [31:0] alu,
                        logic [31:0] ir, logic [21:0] ctrl);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_pc = pc; in_ld_result = ld; in_alu_result = alu;
        in_ir = ir; in_ctrl = ctrl;
        if (!m_halted) begin
            if (ir[31:27] == 5'b11111) begin
                m_halted = 1;
            end else begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (m_cnt3 != 7) m_cnt3++;
                if (ctrl[6]) begin
                    e.data = ctrl[8] ? pc + 32'd4 : (ctrl[1] ? ld : alu);
                    e.rd   = ctrl[8] ? 4'd15 : ir[25:22];
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        m_halted = 0; m_cnt = 0; m_cnt3 = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #3;
        chk("reset_wb_en", {31'b0, wb_en}, 32'd0);
        chk("reset_wb_rd", {28'b0, wb_rd}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);
        chk("reset_cnt", retired_cnt, 32'd0);
        chk("reset_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        send(32'h40, 32'h0, 32'h1234, mkir(5'd0, 4'd3), mkctrl(0, 1, 0));
        idle();
        chk("alu_wb_en", {31'b0, wb_en}, 32'd1);
        chk("alu_wb_rd", {28'b0, wb_rd}, 32'd3);
        chk("alu_wb_data", wb_data, 32'h1234);
        idle();
        chk("alu_pulse_end", {31'b0, wb_en}, 32'd0);
        chk("alu_hold_data", wb_data, 32'h1234);
    endtask

    task automatic test_load_call();
        send(32'h80, 32'hDEADBEEF, 32'h5555, mkir(5'd0, 4'd7), mkctrl(1, 1, 0));
        idle();
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_rd", {28'b0, wb_rd}, 32'd7);
        send(32'h100, 32'h0, 32'h9999, mkir(5'd0, 4'd2), mkctrl(0, 1, 1));
        idle();
        chk("call_wb_data", wb_data, 32'h104);
        chk("call_wb_rd", {28'b0, wb_rd}, 32'd15);
        send(32'h0, 32'h0, 32'hABCD, mkir(5'd0, 4'd15), mkctrl(0, 1, 0));
        idle();
        chk("ra_rd_noncall", {28'b0, wb_rd}, 32'd15);
    endtask

    task automatic test_call_priority_wrap();
        send(32'hFFFF_FFFC, 32'h1111, 32'h2222, mkir(5'd0, 4'd2), mkctrl(1, 1, 1));
        idle();
        chk("wrap_wb_data", wb_data, 32'h0);
        chk("wrap_wb_rd", {28'b0, wb_rd}, 32'd15);
        chk("wrap_wb_en", {31'b0, wb_en}, 32'd1);
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = wb_seen;
        for (int i = 0; i < 5; i++)
            send(32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 32'hA000 + 32'(i),
                 mkir(5'd0, 4'(i + 1)), mkctrl(i[0], (i % 2) == 0, 0));
        idle();
        idle();
        chk("b2b_cnt", retired_cnt, 32'd5);
        chk("b2b_wb_pulses", 32'(wb_seen - base), 32'd3);
    endtask

    task automatic test_halt();
        int base;
        base = wb_seen;
        send(32'h300, 32'h0, 32'h77, mkir(5'b11111, 4'd4), mkctrl(0, 1, 0));
        idle();
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_ready", {31'b0, in_ready}, 32'd0);
        chk("halt_wb_en", {31'b0, wb_en}, 32'd0);
        chk("halt_cnt", retired_cnt, m_cnt);
        for (int i = 0; i < 3; i++)
            send(32'h400, 32'h0, 32'h88, mkir(5'd0, 4'd6), mkctrl(0, 1, 0));
        idle();
        idle();
        chk("halt_ignore_cnt", retired_cnt, m_cnt);
        chk("halt_no_writes", 32'(wb_seen - base), 32'd0);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
    endtask

    task automatic test_async_reset_sat();
        do_reset();
        send(32'h0, 32'h0, 32'h5A5A, mkir(5'd0, 4'd9), mkctrl(0, 1, 0));
        @(posedge clk);
        #2;
        chk("pre_rst_wb_en", {31'b0, wb_en}, 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        m_halted = 0; m_cnt = 0; m_cnt3 = 0;
        #1;
        chk("async_wb_en", {31'b0, wb_en}, 32'd0);
        chk("async_wb_data", wb_data, 32'd0);
        chk("async_wb_rd", {28'b0, wb_rd}, 32'd0);
        chk("async_cnt", retired_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++)
            send(32'h0, 32'h0, 32'(i), mkir(5'd0, 4'd1), mkctrl(0, 0, 0));
        idle();
        chk("sat_cnt3", {29'b0, retired_cnt3}, 32'd7);
        chk("sat_cnt32", retired_cnt, 32'd9);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_call();
        test_call_priority_wrap();
        test_back_to_back();
        test_halt();
        test_async_reset_sat();
        idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
